// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// imem_loader_if : host byte stream + instruction-memory write port
// Revision 1.0
// ============================================================================
interface imem_loader_if #(
  parameter int ADDR_W = 9
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  // master: host link and imem side; slave: the loader
  modport master (output in_valid, in_data, input in_ready, we, waddr, wdata);
  modport slave  (input in_valid, in_data, output in_ready, we, waddr, wdata);
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// imem_loader : boots the instruction memory from a little-endian byte stream.
// Optional trailer checksum enabled by IMEM_LOADER_CSUM_EN.    Revision 1.0
// ============================================================================
module imem_loader #(
  parameter int DEPTH  = 512,
  parameter int ADDR_W = 9
) (
  input  wire logic    clk,
  input  wire logic    reset_n,
  input  wire logic    start,
  imem_loader_if.slave bus,
  output logic         cpu_halt,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [15:0]  words_loaded
);

  localparam logic [16:0] DEPTH_EXT = 17'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_LO = 3'd1,
    CNT_HI = 3'd2,
    DATA   = 3'd3,
`ifdef IMEM_LOADER_CSUM_EN
    CSUM   = 3'd4,
`endif
    FINISH = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic [15:0]       n, n_nx;
  logic [1:0]        byte_idx, byte_idx_nx;
  logic [31:0]       wdata, wdata_nx;
  logic [ADDR_W-1:0] waddr, waddr_nx;
  logic              we, we_nx;
  logic [15:0]       words_nx;
  logic              busy_nx, done_nx, err_nx, halt_nx;
  logic              in_ready, accept, last_word, finish;
  logic [15:0]       n_full;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum, csum_nx;
`endif

`ifdef IMEM_LOADER_CSUM_EN
  assign in_ready = (state == CNT_LO) || (state == CNT_HI) || (state == DATA) || (state == CSUM);
`else
  assign in_ready = (state == CNT_LO) || (state == CNT_HI) || (state == DATA);
`endif

  assign accept    = bus.in_valid && in_ready;
  assign n_full    = {bus.in_data, n[7:0]};
  // words_loaded doubles as the index of the word being assembled
  assign last_word = ((words_loaded + 16'd1) == n);

  assign bus.in_ready = in_ready;
  assign bus.we       = we;
  assign bus.waddr    = waddr;
  assign bus.wdata    = wdata;

  always_comb begin
    state_nx    = state;
    n_nx        = n;
    byte_idx_nx = byte_idx;
    wdata_nx    = wdata;
    waddr_nx    = waddr;
    we_nx       = 1'b0;
    words_nx    = words_loaded;
    busy_nx     = busy;
    done_nx     = 1'b0;
    err_nx      = err;
    halt_nx     = cpu_halt;
    finish      = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
    csum_nx     = csum;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_nx    = CNT_LO;
          busy_nx     = 1'b1;
          halt_nx     = 1'b1;
          err_nx      = 1'b0;
          words_nx    = 16'd0;
          byte_idx_nx = 2'd0;
`ifdef IMEM_LOADER_CSUM_EN
          csum_nx     = 8'd0;
`endif
        end
      end
      CNT_LO: begin
        if (accept) begin
          n_nx[7:0] = bus.in_data;
          state_nx  = CNT_HI;
        end
      end
      CNT_HI: begin
        if (accept) begin
          n_nx = n_full;
          if (n_full == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_nx = CSUM;
`else
            finish = 1'b1;
`endif
          end else begin
            // oversize images are still consumed in full, only flagged
            if ({1'b0, n_full} > DEPTH_EXT) err_nx = 1'b1;
            state_nx = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          wdata_nx[{byte_idx, 3'b000} +: 8] = bus.in_data;
          byte_idx_nx = byte_idx + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
          csum_nx = csum + bus.in_data;
`endif
          if (byte_idx == 2'd3) begin
            we_nx    = ({1'b0, words_loaded} < DEPTH_EXT);
            waddr_nx = words_loaded[ADDR_W-1:0];
            words_nx = words_loaded + 16'd1;
            if (last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
              state_nx = CSUM;
`else
              finish = 1'b1;
`endif
            end
          end
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: begin
        if (accept) begin
          if (bus.in_data != csum) err_nx = 1'b1;
          finish = 1'b1;
        end
      end
`endif
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    // a failed session keeps the core halted until the next good load
    if (finish) begin
      state_nx = FINISH;
      busy_nx  = 1'b0;
      if (!err_nx) begin
        done_nx = 1'b1;
        halt_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      n            <= 16'd0;
      byte_idx     <= 2'd0;
      wdata        <= 32'd0;
      waddr        <= '0;
      we           <= 1'b0;
      words_loaded <= 16'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      cpu_halt     <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
      csum         <= 8'd0;
`endif
    end else begin
      state        <= state_nx;
      n            <= n_nx;
      byte_idx     <= byte_idx_nx;
      wdata        <= wdata_nx;
      waddr        <= waddr_nx;
      we           <= we_nx;
      words_loaded <= words_nx;
      busy         <= busy_nx;
      done         <= done_nx;
      err          <= err_nx;
      cpu_halt     <= halt_nx;
`ifdef IMEM_LOADER_CSUM_EN
      csum         <= csum_nx;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// tb_imem_loader : table vectors, directed corner cases and randomized images
// checked against a behavioural model of the boot loader.
module tb_imem_loader;
  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;
`ifdef IMEM_LOADER_CSUM_EN
  localparam int TR = 1;
`else
  localparam int TR = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        cpu_halt, busy, done, err;
  logic [15:0] words_loaded;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bus(bus),
    .cpu_halt(cpu_halt), .busy(busy), .done(done), .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] a; logic [31:0] d; } wr_t;
  typedef struct {
    int nb; logic [95:0] b; int gap; bit poke;
    int nwr; logic [31:0] d0; logic [31:0] d1; int words; bit e;
  } vec_t;

  wr_t         wq[$];
  logic [31:0] exp_q[$];
  int          exp_words;
  bit          exp_err;
  int          done_cnt, writes_at_done;
  logic        done_after_last, halt_after_last;
  int          n_vec = 0, n_miss = 0;
  vec_t        tbl[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.we) wq.push_back('{bus.waddr, bus.wdata});
      if (done) begin
        done_cnt++;
        writes_at_done = wq.size();
        check("done_release", {30'd0, busy, cpu_halt}, 32'd0);
      end
      if (busy) check("halt_while_busy", cpu_halt, 1);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL in_ready_timeout: got in_ready 0, required 1");
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
  endtask

  task automatic run_session(input logic [7:0] img[$], input int gmin, input int gmax, input bit poke);
    int n;
    int t = 0;
    n = {img[1], img[0]};
    wq.delete();
    done_cnt = 0;
    writes_at_done = -1;
    pulse_start();
    check("start_busy", busy, 1);
    check("start_halt", cpu_halt, 1);
    check("start_err_clr", err, 0);
    check("start_words", words_loaded, 0);
    foreach (img[i]) begin
      send_byte(img[i]);
      if (i >= 2 && (i - 2) < 4 * n) begin
        int j = i - 2;
        if (j % 4 == 3) begin
          check("we_pulse", bus.we, (j / 4 < DEPTH));
          check("words_inc", words_loaded, j / 4 + 1);
        end else begin
          check("we_idle", bus.we, 0);
        end
      end
      if (i == img.size() - 1) begin
        done_after_last = done;
        halt_after_last = cpu_halt;
      end else begin
        int g = (gmin == gmax) ? gmin : int'($urandom_range(gmax, gmin));
        for (int k = 0; k < g; k++) begin
          if (poke && k == 0) start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("session_end", busy, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_session(input string tag);
    int bad = 0;
    check({tag, "_nwr"}, wq.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < wq.size())
        if (wq[i].a !== ADDR_W'(i) || wq[i].d !== exp_q[i]) bad++;
    check({tag, "_wrdata_bad"}, bad, 0);
    check({tag, "_words"}, words_loaded, exp_words);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_done_cnt"}, done_cnt, exp_err ? 0 : 1);
    check({tag, "_halt"}, cpu_halt, exp_err);
    check({tag, "_busy"}, busy, 0);
    if (!exp_err) begin
      check({tag, "_done_timing"}, done_after_last, 1);
      check({tag, "_halt_timing"}, halt_after_last, 0);
      check({tag, "_writes_before_done"}, writes_at_done, exp_q.size());
    end
  endtask

  // Reference: N words of 4 LE bytes, only the first DEPTH written, trailer = byte sum.
  task automatic model(input logic [7:0] img[$]);
    int n;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] s = 8'd0;
`endif
    n = {img[1], img[0]};
    exp_q.delete();
    for (int w = 0; w < n; w++)
      if (w < DEPTH)
        exp_q.push_back({img[2 + 4*w + 3], img[2 + 4*w + 2], img[2 + 4*w + 1], img[2 + 4*w]});
    exp_words = n;
    exp_err   = (n > DEPTH);
`ifdef IMEM_LOADER_CSUM_EN
    for (int k = 0; k < 4 * n; k++) s += img[2 + k];
    if (img[2 + 4 * n] != s) exp_err = 1'b1;
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_we"}, bus.we, 0);
    check({tag, "_waddr"}, bus.waddr, 0);
    check({tag, "_wdata"}, bus.wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_halt"}, cpu_halt, 0);
    check({tag, "_words"}, words_loaded, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst_init");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready", bus.in_ready, 0);
    check("idle_we", bus.we, 0);

    // nb, bytes (byte k at [8k+:8], trailer included), gap, poke, nwr, d0, d1, words, err
    tbl[0] = '{10 + TR, 96'h00B6_0010_0093_0000_0013_0002, 0, 1'b0, 2, 32'h0000_0013, 32'h0010_0093, 2, 1'b0};
    tbl[1] = '{10 + TR, 96'h00B6_0010_0093_0000_0013_0002, 3, 1'b1, 2, 32'h0000_0013, 32'h0010_0093, 2, 1'b0};
    tbl[2] = '{2 + TR,  96'h0,                             0, 1'b0, 0, 32'h0,         32'h0,         0, 1'b0};
    tbl[3] = '{6 + TR,  96'h0000_0000_0038_DEAD_BEEF_0001, 1, 1'b0, 1, 32'hDEAD_BEEF, 32'h0,         1, 1'b0};
`ifdef IMEM_LOADER_CSUM_EN
    tbl[4] = '{11,      96'h00B7_0010_0093_0000_0013_0002, 0, 1'b0, 2, 32'h0000_0013, 32'h0010_0093, 2, 1'b1};
`else
    tbl[4] = '{6,       96'h0000_0000_0014_1234_5678_0001, 2, 1'b0, 1, 32'h1234_5678, 32'h0,         1, 1'b0};
`endif

    for (int i = 0; i < 5; i++) begin
      logic [7:0] img[$];
      img = {};
      for (int k = 0; k < tbl[i].nb; k++) img.push_back(tbl[i].b[8*k +: 8]);
      run_session(img, tbl[i].gap, tbl[i].gap, tbl[i].poke);
      exp_q.delete();
      if (tbl[i].nwr > 0) exp_q.push_back(tbl[i].d0);
      if (tbl[i].nwr > 1) exp_q.push_back(tbl[i].d1);
      exp_words = tbl[i].words;
      exp_err   = tbl[i].e;
      check_session($sformatf("tbl%0d", i));
    end

    // oversize image: N = 513, only words 0..511 may reach memory
    begin
      logic [7:0] img[$];
`ifdef IMEM_LOADER_CSUM_EN
      logic [7:0] s = 8'd0;
`endif
      img = {};
      img.push_back(8'h01);
      img.push_back(8'h02);
      for (int k = 0; k < 2052; k++) img.push_back(8'(k));
`ifdef IMEM_LOADER_CSUM_EN
      for (int k = 0; k < 2052; k++) s += 8'(k);
      img.push_back(s);
`endif
      model(img);
      run_session(img, 0, 0, 1'b0);
      check_session("ovf");
      check("ovf_last_addr", wq.size() > 0 ? 32'(wq[wq.size()-1].a) : 32'hFFFF_FFFF, 511);
    end

    // recovery after the error: clean reload from address 0
    begin
      logic [7:0] img[$];
      img = {};
      for (int k = 0; k < tbl[0].nb; k++) img.push_back(tbl[0].b[8*k +: 8]);
      model(img);
      run_session(img, 0, 1, 1'b0);
      check_session("recover");
    end

    for (int r = 0; r < 25; r++) begin
      logic [7:0] img[$];
      int n;
`ifdef IMEM_LOADER_CSUM_EN
      logic [7:0] s;
`endif
      n = $urandom_range(6, 0);
      img = {};
      img.push_back(8'(n));
      img.push_back(8'h00);
      for (int k = 0; k < 4 * n; k++) img.push_back(8'($urandom));
`ifdef IMEM_LOADER_CSUM_EN
      s = 8'd0;
      for (int k = 0; k < 4 * n; k++) s += img[2 + k];
      if ($urandom_range(3, 0) == 0) s = s + 8'(1 + $urandom_range(254, 0));
      img.push_back(s);
`endif
      model(img);
      run_session(img, 0, 2, 1'b1);
      check_session("rand");
    end

    // reset in the middle of a word: nothing written, everything cleared
    wq.delete();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_idle_ready", bus.in_ready, 0);
      check("rst_idle_we", bus.we, 0);
    end
    check("rst_no_write", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot/reload controller for the core's word-addressed instruction memory.
- Receives a byte stream from a host link (UART receiver or debug port), assembles little-endian 32-bit instruction words, and drives the imem write port at sequential word addresses from 0.
- Holds the single-cycle core halted while loading; releases it when the image is complete.

Parameters:
- DEPTH, 512, number of 32-bit words in instruction memory.
- ADDR_W, 9, width of word address; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  pulse; begins a load session; honoured only in IDLE.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  loader accepts a byte this cycle.
- we  output  1  imem write enable, one-cycle pulse per word.
- waddr  output  ADDR_W  imem word address.
- wdata  output  32  imem write data.
- cpu_halt  output  1  holds core PC/regfile frozen.
- busy  output  1  session in progress.
- done  output  1  one-cycle pulse, successful completion.
- err  output  1  sticky error; cleared by next accepted start.
- words_loaded  output  16  count of words written this session.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE.
  - in_ready, we, busy, done, err, cpu_halt = 0.
  - waddr, wdata, words_loaded = 0.
  - Byte index = 0.
- Handshake: a byte is accepted when in_valid && in_ready.
  - in_ready = 1 in CNT_LO, CNT_HI, DATA, and CSUM (CSUM only with the optional feature); 0 elsewhere.
  - in_data is ignored when no byte is accepted.
- States:
  - IDLE, start=1 -> CNT_LO. Next edge: busy=1, cpu_halt=1, err=0, words_loaded=0, byte index=0.
  - CNT_LO: accepted byte -> N[7:0] -> CNT_HI.
  - CNT_HI: accepted byte -> N[15:8].
    - If N==0 -> FINISH.
    - Else if N>DEPTH: err=1, then -> DATA.
    - Else -> DATA.
  - DATA: bytes fill wdata LSB-first (byte0 -> [7:0] ... byte3 -> [31:24]).
    - On the 4th accepted byte of a word: next cycle we=1 for one cycle, with waddr = word index and wdata stable.
    - words_loaded increments in the same cycle that we=1.
    - Word indices >= DEPTH: bytes are consumed, we stays 0, words_loaded still increments.
    - After word N-1 is assembled -> FINISH (or CSUM if enabled).
  - FINISH (one cycle; entered the cycle the final we is asserted, or directly from CNT_HI when N==0):
    - busy=0.
    - If err==0: done=1 for one cycle and cpu_halt falls on the same edge.
    - If err==1: cpu_halt stays 1, done stays 0.
    - -> IDLE.
- cpu_halt never falls before the last we has been issued.
- Gaps and back-pressure: in_valid may drop between any bytes; state and partial word are held indefinitely. There is no timeout.
- start outside IDLE is ignored.
- Session after an error: a new start clears err and reloads from address 0.
- Reset mid-load: all registers return to reset values; cpu_halt drops to 0. Words already written stay in imem; no partial word is written.
- waddr width: word index truncated to ADDR_W bits, used only when index < DEPTH.

Optional Feature:
- Macro IMEM_LOADER_CSUM_EN.
- Defined:
  - After the last data byte, state CSUM accepts one trailer byte.
  - The expected value is the 8-bit modular sum of all N*4 data bytes; count bytes are excluded.
  - Mismatch sets err=1: cpu_halt stays 1, no done.
  - Match -> FINISH. cpu_halt falls on FINISH, one cycle after the trailer handshake.
  - For N==0, the trailer is still required and must be 0x00.
- Undefined: no CSUM state and no trailer byte; DATA goes directly to FINISH.

Test Plan:
- Reset check: reset_n=0 mid-run -> all outputs 0; after release with start=0 -> in_ready=0, no we.
- Nominal load: start, then bytes 02 00 13 00 00 00 93 00 10 00 -> we@waddr0 wdata 0x00000013; we@waddr1 wdata 0x00100093; then done pulse with cpu_halt 1->0; words_loaded=2; err=0.
- Empty image: start, bytes 00 00 -> no we; done one cycle after CNT_HI handshake; cpu_halt back to 0.
- Stall tolerance: nominal image with in_valid low 3 cycles between every byte, plus start pulsed during DATA -> identical writes; start ignored; single done.
- Overflow: DEPTH=512, N=513 (bytes 01 02) plus 2052 data bytes -> 512 we pulses (waddr 0..511); no 513th write; words_loaded=513; err=1; cpu_halt stays 1; no done. A new start clears err.
- IMEM_LOADER_CSUM_EN: nominal image + trailer 0xB6 -> done; trailer 0xB7 -> err=1, cpu_halt=1.
